// File: rtl/wb_io_ctrl.sv
// wb_io_ctrl: Wishbone slave register block for the 38 user GPIO pads.
// Holds the pad output values and output enables, and synchronises the pad inputs.
// Detects rising input edges into a sticky W1C status register.
// Drives a registered, maskable level interrupt intended for user_irq[0].
module wb_io_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned NUM_IO   = 38
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic              irq_o
);

    // Width of the HI words; the pad count is fixed at 38, so this is 6.
    localparam int unsigned HI_W = NUM_IO - 32;

    // Word indices (byte offset / 4) inside the 256-byte window.
    localparam logic [5:0] IDX_OUT_LO     = 6'd0;
    localparam logic [5:0] IDX_OUT_HI     = 6'd1;
    localparam logic [5:0] IDX_OEB_LO     = 6'd2;
    localparam logic [5:0] IDX_OEB_HI     = 6'd3;
    localparam logic [5:0] IDX_IN_LO      = 6'd4;
    localparam logic [5:0] IDX_IN_HI      = 6'd5;
    localparam logic [5:0] IDX_IRQ_EN_LO  = 6'd6;
    localparam logic [5:0] IDX_IRQ_EN_HI  = 6'd7;
    localparam logic [5:0] IDX_IRQ_ST_LO  = 6'd8;
    localparam logic [5:0] IDX_IRQ_ST_HI  = 6'd9;

    // Architectural registers
    logic [NUM_IO-1:0] out_q;
    logic [NUM_IO-1:0] oeb_q;
    logic [NUM_IO-1:0] irq_en_q;
    logic [NUM_IO-1:0] irq_stat_q;

    // Input path flops
    logic [NUM_IO-1:0] sync1_q;
    logic [NUM_IO-1:0] sync2_q;
    logic [NUM_IO-1:0] prev_q;

    // Next-state values and strobes
    logic [NUM_IO-1:0] out_d;
    logic [NUM_IO-1:0] oeb_d;
    logic [NUM_IO-1:0] irq_en_d;
    logic [NUM_IO-1:0] irq_stat_d;
    logic [NUM_IO-1:0] clr_mask;
    logic [NUM_IO-1:0] rise;

    // Bus side
    logic              ack_q;
    logic [31:0]       dat_q;
    logic              irq_q;
    logic [31:0]       rd_data;
    logic              adr_match;
    logic              req;
    logic              wr_req;
    logic              rd_req;
    logic [5:0]        word_idx;
    logic [31:0]       lane_mask;
    logic [1:0]        unused_adr;

    // The window is selected by the upper 24 address bits only.
    assign adr_match  = (wbs_adr_i[31:8] == BASE_ADR[31:8]);

    // Gating with the current ack keeps acks from ever landing in adjacent cycles.
    assign req        = wbs_stb_i & wbs_cyc_i & adr_match & ~ack_q;
    assign wr_req     = req & wbs_we_i;
    assign rd_req     = req & ~wbs_we_i;
    assign word_idx   = wbs_adr_i[7:2];
    assign unused_adr = wbs_adr_i[1:0];

    // Expand the byte selects into a per-bit write mask.
    assign lane_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                         {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    // A rising edge is seen when the synchronised value is high and was low last cycle.
    assign rise = sync2_q & ~prev_q;

    // Compute the register updates for a committed write, honouring byte selects.
    always_comb begin
        out_d    = out_q;
        oeb_d    = oeb_q;
        irq_en_d = irq_en_q;
        clr_mask = '0;
        if (wr_req) begin
            case (word_idx)
                IDX_OUT_LO: begin
                    out_d[31:0] = (out_q[31:0] & ~lane_mask) | (wbs_dat_i & lane_mask);
                end
                IDX_OUT_HI: begin
                    out_d[NUM_IO-1:32] = (out_q[NUM_IO-1:32] & ~lane_mask[HI_W-1:0])
                                       | (wbs_dat_i[HI_W-1:0] & lane_mask[HI_W-1:0]);
                end
                IDX_OEB_LO: begin
                    oeb_d[31:0] = (oeb_q[31:0] & ~lane_mask) | (wbs_dat_i & lane_mask);
                end
                IDX_OEB_HI: begin
                    oeb_d[NUM_IO-1:32] = (oeb_q[NUM_IO-1:32] & ~lane_mask[HI_W-1:0])
                                       | (wbs_dat_i[HI_W-1:0] & lane_mask[HI_W-1:0]);
                end
                IDX_IRQ_EN_LO: begin
                    irq_en_d[31:0] = (irq_en_q[31:0] & ~lane_mask) | (wbs_dat_i & lane_mask);
                end
                IDX_IRQ_EN_HI: begin
                    irq_en_d[NUM_IO-1:32] = (irq_en_q[NUM_IO-1:32] & ~lane_mask[HI_W-1:0])
                                          | (wbs_dat_i[HI_W-1:0] & lane_mask[HI_W-1:0]);
                end
                IDX_IRQ_ST_LO: begin
                    clr_mask[31:0] = wbs_dat_i & lane_mask;
                end
                IDX_IRQ_ST_HI: begin
                    clr_mask[NUM_IO-1:32] = wbs_dat_i[HI_W-1:0] & lane_mask[HI_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Clear is applied before the set so a coincident rising edge keeps the bit high.
    always_comb begin
        irq_stat_d = (irq_stat_q & ~clr_mask) | rise;
    end

    // Read multiplexer; unmapped offsets and the unused HI bits read as zero.
    always_comb begin
        rd_data = '0;
        case (word_idx)
            IDX_OUT_LO:    rd_data = out_q[31:0];
            IDX_OUT_HI:    rd_data = {{(32-HI_W){1'b0}}, out_q[NUM_IO-1:32]};
            IDX_OEB_LO:    rd_data = oeb_q[31:0];
            IDX_OEB_HI:    rd_data = {{(32-HI_W){1'b0}}, oeb_q[NUM_IO-1:32]};
            IDX_IN_LO:     rd_data = sync2_q[31:0];
            IDX_IN_HI:     rd_data = {{(32-HI_W){1'b0}}, sync2_q[NUM_IO-1:32]};
            IDX_IRQ_EN_LO: rd_data = irq_en_q[31:0];
            IDX_IRQ_EN_HI: rd_data = {{(32-HI_W){1'b0}}, irq_en_q[NUM_IO-1:32]};
            IDX_IRQ_ST_LO: rd_data = irq_stat_q[31:0];
            IDX_IRQ_ST_HI: rd_data = {{(32-HI_W){1'b0}}, irq_stat_q[NUM_IO-1:32]};
            default:       rd_data = '0;
        endcase
    end

    // Bus handshake: one-cycle ack after each request, read data valid only with ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= rd_req ? rd_data : 32'h0;
        end
    end

    // Control registers commit on the same edge that raises ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q    <= '0;
            oeb_q    <= '1;
            irq_en_q <= '0;
        end else begin
            out_q    <= out_d;
            oeb_q    <= oeb_d;
            irq_en_q <= irq_en_d;
        end
    end

    // Two-flop synchroniser for the asynchronous pads plus a history flop for edge detect.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Sticky status latches every edge regardless of enable; the interrupt line is registered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_stat_q <= irq_stat_d;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = out_q;
    assign io_oeb    = oeb_q;
    assign irq_o     = irq_q;

endmodule

// File: doc/wb_io_ctrl.md
Name: wb_io_ctrl

Overview:
- Wishbone slave register block inside the user project area, directly downstream of the Caravel management Wishbone port.
- Drives the 38 user GPIO output and output-enable lines.
- Samples and synchronises the 38 GPIO inputs.
- Raises a maskable interrupt on rising input edges, for connection to user_irq[0].

Parameters:
- BASE_ADR, 32'h3000_0000, base of the 256-byte register window; match is on wbs_adr_i[31:8] == BASE_ADR[31:8].
- NUM_IO, 38, GPIO count; fixed at 38, split into LO (bits 31:0) and HI (bits 37:32) words.

Ports:
- wb_clk_i  input  1  single clock for all logic.
- wb_rst_i  input  1  reset; synchronous, active-high.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects; honoured on writes.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  byte address.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- io_in  input  38  pad inputs, asynchronous to wb_clk_i.
- io_out  output  38  pad output values.
- io_oeb  output  38  pad output enables, active-low.
- irq_o  output  1  level interrupt = |(IRQ_STAT & IRQ_EN).

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high; all state resets on the clock edge where it is sampled high.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - OUT=0, so io_out=0.
  - OEB=all ones, so io_oeb=38'h3F_FFFF_FFFF and all pads are inputs.
  - IRQ_EN=0, IRQ_STAT=0, irq_o=0.
  - Synchroniser and edge flops=0.
- Register map (offset from BASE_ADR; HI words use bits 5:0, upper bits read 0 and are write-ignored):
  - 0x00 OUT_LO RW; 0x04 OUT_HI RW.
  - 0x08 OEB_LO RW; 0x0C OEB_HI RW.
  - 0x10 IN_LO RO; 0x14 IN_HI RO.
  - 0x18 IRQ_EN_LO RW; 0x1C IRQ_EN_HI RW.
  - 0x20 IRQ_STAT_LO W1C; 0x24 IRQ_STAT_HI W1C.
  - Other offsets in the window: acked; reads return 0; writes are ignored.
- Wishbone handshake:
  - A request is stb&cyc&address match&!ack.
  - ack is asserted the cycle after the request, for exactly one cycle. ack is never asserted in back-to-back cycles; a held strobe gets its next ack two cycles later.
  - Outside the window: no ack, wbs_dat_o=0.
  - Write data commits on the same edge that raises ack; byte lane n is written only if wbs_sel_i[n]=1.
  - Read data is registered and valid while ack=1; wbs_dat_o=0 when ack=0.
- Input path:
  - Two-flop synchroniser on io_in, then a third "prev" flop.
  - IN registers show the synchroniser output, so latency from a stable io_in change to IN visibility is 2 cycles.
- Edge detect: rise[i] = sync[i] & ~prev[i]. The IRQ_STAT bit sets one edge later and is sticky until cleared.
- W1C: writing 1 to a selected byte bit clears that IRQ_STAT bit. If a rise and a clear hit the same bit in the same cycle, set wins (bit stays 1).
- Interrupt: irq_o is registered, asserting one cycle after the STAT/EN condition becomes true. Masked bits still latch in IRQ_STAT.
- Reset during a bus cycle: ack is dropped and no write commits; the master must retry.
- Pad outputs: io_out and io_oeb are driven directly from the OUT and OEB registers, with no extra latency after write commit.

Test Plan:
- Reset then read OEB_LO/OEB_HI/OUT_LO -> 0xFFFF_FFFF / 0x0000_003F / 0x0000_0000; io_oeb=all ones; each ack is a 1-cycle pulse arriving 1 cycle after strobe.
- Write OUT_LO=0xA5A5_A5A5 with sel=4'b0101 -> io_out[31:0]=0x00A5_00A5 on the ack edge; readback gives the same; write OUT_HI=0xFFFF_FFFF -> reads 0x3F.
- Drive io_in[33]=1 with IRQ_EN_HI bit1=1 -> IN_HI reads 0x02 after 2 cycles; IRQ_STAT_HI=0x02; irq_o=1. Write 0x02 to IRQ_STAT_HI -> STAT=0 and irq_o=0 the next cycle.
- Rising edge on io_in[0] coincident with the W1C clear of bit0 -> IRQ_STAT_LO bit0 remains 1 and irq_o stays high if enabled.
- Access BASE_ADR+0x40 reads 0 with ack; access 0x3100_0000 -> no ack for 10 cycles and wbs_dat_o=0.
- Assert wb_rst_i in the cycle a write to OUT_LO is requested -> no ack, OUT_LO stays 0, all outputs at reset values.
